btb_2way: RTL and testbench

BTB_2WAY -- requirements
Module: btb_2way

---
 rtl/btb_2way_if.sv | 38 +++
 rtl/btb_2way.sv | 159 +++++++++++++++
 tb/tb_btb_2way.sv | 137 +++++++++++++
 3 files changed

// File: rtl/btb_2way_if.sv
// btb_2way_if -- IF-lookup / EX-update bus of the 2-way branch target buffer.
//   IF side : if_pc -> hit, predicted_taken, target_pc, read_index,
//             branch1_used, branch2_used; lru_read_bit from the LRU block.
//   EX side : ex_valid, ex_pc, ex_target, ex_taken, lru_write_bit ->
//             update_index, new_entry, insert_branch1, insert_branch2.
//   master  : pipeline / LRU side driving the requests.
//   slave   : the BTB itself.
interface btb_2way_if;
  logic [31:0] if_pc;
  logic        hit;
  logic        predicted_taken;
  logic [31:0] target_pc;
  logic [2:0]  read_index;
  logic        branch1_used;
  logic        branch2_used;
  logic        lru_read_bit;
  logic        ex_valid;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_taken;
  logic [2:0]  update_index;
  logic        new_entry;
  logic        insert_branch1;
  logic        insert_branch2;
  logic        lru_write_bit;

  modport master (
    output if_pc, lru_read_bit, ex_valid, ex_pc, ex_target, ex_taken, lru_write_bit,
    input  hit, predicted_taken, target_pc, read_index, branch1_used, branch2_used,
    input  update_index, new_entry, insert_branch1, insert_branch2
  );

  modport slave (
    input  if_pc, lru_read_bit, ex_valid, ex_pc, ex_target, ex_taken, lru_write_bit,
    output hit, predicted_taken, target_pc, read_index, branch1_used, branch2_used,
    output update_index, new_entry, insert_branch1, insert_branch2
  );
endinterface

// File: rtl/btb_2way.sv
// btb_2way -- 8-set x 2-way branch target buffer.
//   Ports: clk, rst (sync, active-high), bus (btb_2way_if.slave).
//   IF lookup is combinational from current storage; EX updates/allocations
//   land on the next rising edge. Way1 wins when both ways match.
//   Build option: define BTB_PREDICTOR_EN for per-entry 2-bit saturating
//   counters. Without it, predicted_taken = hit and a not-taken resolution
//   of a hit entry invalidates that entry.

// One way of storage: two combinational read ports (IF, EX), one write port
// addressed by the EX index.
module btb_way (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  if_idx,
  input  logic [2:0]  ex_idx,
  output logic        if_valid,
  output logic [26:0] if_tag,
  output logic [31:0] if_target,
  output logic        ex_valid,
  output logic [26:0] ex_tag,
`ifdef BTB_PREDICTOR_EN
  output logic [1:0]  if_ctr,
  output logic [1:0]  ex_ctr,
  input  logic [1:0]  wr_ctr,
`endif
  input  logic        wr_en,
  input  logic        wr_valid,
  input  logic [26:0] wr_tag,
  input  logic        wr_tgt_en,
  input  logic [31:0] wr_target
);
  localparam int NUM_SETS = 8;

  logic [NUM_SETS-1:0] valid_q;
  logic [26:0]         tag_q [NUM_SETS];
  logic [31:0]         tgt_q [NUM_SETS];
`ifdef BTB_PREDICTOR_EN
  logic [1:0]          ctr_q [NUM_SETS];
`endif

  assign if_valid  = valid_q[if_idx];
  assign if_tag    = tag_q[if_idx];
  assign if_target = tgt_q[if_idx];
  assign ex_valid  = valid_q[ex_idx];
  assign ex_tag    = tag_q[ex_idx];
`ifdef BTB_PREDICTOR_EN
  assign if_ctr    = ctr_q[if_idx];
  assign ex_ctr    = ctr_q[ex_idx];
`endif

  // Only valid bits are reset; payload is don't-care while invalid. Reset
  // also blocks the write so a same-cycle allocation is dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[ex_idx] <= wr_valid;
      tag_q[ex_idx]   <= wr_tag;
      if (wr_tgt_en) tgt_q[ex_idx] <= wr_target;
`ifdef BTB_PREDICTOR_EN
      ctr_q[ex_idx]   <= wr_ctr;
`endif
    end
  end
endmodule

module btb_2way (
  input logic      clk,
  input logic      rst,
  btb_2way_if.slave bus
);
  localparam int NUM_WAYS = 2;

  logic [2:0]  if_idx, ex_idx;
  logic [26:0] if_tag, ex_tag;

  logic [NUM_WAYS-1:0]       if_v, ex_v, if_m, ex_m, upd, ins;
  logic [NUM_WAYS-1:0]       wr_en, wr_valid, wr_tgt_en;
  logic [NUM_WAYS-1:0][26:0] if_tg, ex_tg;
  logic [NUM_WAYS-1:0][31:0] if_tgt;
`ifdef BTB_PREDICTOR_EN
  logic [NUM_WAYS-1:0][1:0]  if_ctr, ex_ctr, nxt_ctr;
`endif

  assign if_idx = bus.if_pc[4:2];
  assign if_tag = bus.if_pc[31:5];
  assign ex_idx = bus.ex_pc[4:2];
  assign ex_tag = bus.ex_pc[31:5];

  for (genvar w = 0; w < NUM_WAYS; w++) begin : g_way
    btb_way u_way (
      .clk       (clk),
      .rst       (rst),
      .if_idx    (if_idx),
      .ex_idx    (ex_idx),
      .if_valid  (if_v[w]),
      .if_tag    (if_tg[w]),
      .if_target (if_tgt[w]),
      .ex_valid  (ex_v[w]),
      .ex_tag    (ex_tg[w]),
`ifdef BTB_PREDICTOR_EN
      .if_ctr    (if_ctr[w]),
      .ex_ctr    (ex_ctr[w]),
      .wr_ctr    (nxt_ctr[w]),
`endif
      .wr_en     (wr_en[w]),
      .wr_valid  (wr_valid[w]),
      .wr_tag    (ex_tag),
      .wr_tgt_en (wr_tgt_en[w]),
      .wr_target (bus.ex_target)
    );

    assign if_m[w] = if_v[w] && (if_tg[w] == if_tag);
    assign ex_m[w] = ex_v[w] && (ex_tg[w] == ex_tag);

`ifdef BTB_PREDICTOR_EN
    // Fresh allocation starts weakly taken; otherwise saturate toward ex_taken.
    always_comb begin
      nxt_ctr[w] = ex_ctr[w];
      if (ins[w])                                  nxt_ctr[w] = 2'b10;
      else if (bus.ex_taken && ex_ctr[w] != 2'b11)  nxt_ctr[w] = ex_ctr[w] + 2'b01;
      else if (!bus.ex_taken && ex_ctr[w] != 2'b00) nxt_ctr[w] = ex_ctr[w] - 2'b01;
    end
`endif
  end

  // IF lookup: way1 has priority on a double match.
  assign bus.read_index   = if_idx;
  assign bus.hit          = |if_m;
  assign bus.branch1_used = if_m[0];
  assign bus.branch2_used = if_m[1] & ~if_m[0];
  assign bus.target_pc    = if_m[0] ? if_tgt[0] : (if_m[1] ? if_tgt[1] : 32'h0);
`ifdef BTB_PREDICTOR_EN
  assign bus.predicted_taken = if_m[0] ? if_ctr[0][1] : (if_m[1] & if_ctr[1][1]);
`else
  assign bus.predicted_taken = |if_m;
`endif

  // EX side: update the first matching way, or allocate on a taken miss.
  assign bus.update_index = ex_idx;
  assign upd[0]           = bus.ex_valid & ex_m[0];
  assign upd[1]           = bus.ex_valid & ex_m[1] & ~ex_m[0];
  assign bus.new_entry    = bus.ex_valid & bus.ex_taken & ~|ex_m;
  // Invalid way1 first, then invalid way2, then LRU victim
  // (lru_write_bit=1 means way2 was most recent, so evict way1).
  assign ins[0]             = bus.new_entry & (~ex_v[0] | (ex_v[1] & bus.lru_write_bit));
  assign ins[1]             = bus.new_entry & ~ins[0];
  assign bus.insert_branch1 = ins[0];
  assign bus.insert_branch2 = ins[1];

  assign wr_en     = ins | upd;
  assign wr_tgt_en = ins | (upd & {NUM_WAYS{bus.ex_taken}});
`ifdef BTB_PREDICTOR_EN
  assign wr_valid  = '1;
`else
  // Without counters a not-taken resolution drops the entry.
  assign wr_valid  = ins | {NUM_WAYS{bus.ex_taken}};
`endif
endmodule

// File: tb/tb_btb_2way.sv
// tb_btb_2way -- directed, table-driven bench for btb_2way. Each record is one
// clock cycle: inputs driven after the rising edge, outputs checked on the
// falling edge (combinational view of pre-update state).
module tb_btb_2way;
  logic clk = 1'b0;
  logic rst;
  btb_2way_if bus();

  btb_2way u_dut (.clk(clk), .rst(rst), .bus(bus.slave));

  always #5 clk = ~clk;

  typedef struct {
    logic        chk;
    logic        r;
    logic [31:0] ipc;
    logic        ev;
    logic [31:0] epc;
    logic [31:0] etg;
    logic        et;
    logic        lru;
    logic        hit;
    logic        pt;
    logic [31:0] tgt;
    logic        b1;
    logic        b2;
    logic        ne;
    logic        i1;
    logic        i2;
  } vec_t;

  int n_cmp = 0;
  int n_bad = 0;

  function automatic vec_t mk(logic r, logic [31:0] ipc, logic ev, logic [31:0] epc,
                              logic [31:0] etg, logic et, logic lru,
                              logic hit, logic pt, logic [31:0] tgt,
                              logic b1, logic b2, logic ne, logic i1, logic i2);
    vec_t v;
    v.chk = ~r; v.r = r; v.ipc = ipc; v.ev = ev; v.epc = epc; v.etg = etg;
    v.et = et; v.lru = lru; v.hit = hit; v.pt = pt; v.tgt = tgt;
    v.b1 = b1; v.b2 = b2; v.ne = ne; v.i1 = i1; v.i2 = i2;
    return v;
  endfunction

  // Lookup-only cycle.
  function automatic vec_t lk(logic [31:0] ipc, logic hit, logic pt, logic [31:0] tgt,
                              logic b1, logic b2);
    return mk(1'b0, ipc, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, hit, pt, tgt, b1, b2, 1'b0, 1'b0, 1'b0);
  endfunction

  task automatic apply(input vec_t v, input int id);
    logic [44:0] act, exp;
    rst               = v.r;
    bus.if_pc         = v.ipc;
    bus.lru_read_bit  = 1'b0;
    bus.ex_valid      = v.ev;
    bus.ex_pc         = v.epc;
    bus.ex_target     = v.etg;
    bus.ex_taken      = v.et;
    bus.lru_write_bit = v.lru;
    @(negedge clk);
    if (v.chk) begin
      act = {bus.hit, bus.predicted_taken, bus.target_pc, bus.branch1_used, bus.branch2_used,
             bus.new_entry, bus.insert_branch1, bus.insert_branch2,
             bus.read_index, bus.update_index};
      exp = {v.hit, v.pt, v.tgt, v.b1, v.b2, v.ne, v.i1, v.i2, v.ipc[4:2], v.epc[4:2]};
      n_cmp++;
      if (act !== exp) begin
        n_bad++;
        $display("FAIL vec%0d: got {hit,pt,tgt,b1,b2,ne,i1,i2,ridx,uidx}=%h need %h", id, act, exp);
      end
    end
    @(posedge clk);
    #1;
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1;
    bus.if_pc = '0; bus.lru_read_bit = 1'b0; bus.ex_valid = 1'b0; bus.ex_pc = '0;
    bus.ex_target = '0; bus.ex_taken = 1'b0; bus.lru_write_bit = 1'b0;

    //               rst  if_pc   ev  ex_pc   ex_tgt   et lru | hit pt target   b1 b2 ne i1 i2
    tbl.push_back(mk(1, 32'h40, 0, 32'h0,  32'h0,    0, 0,   0, 0, 32'h0,    0, 0, 0, 0, 0));
    tbl.push_back(lk(32'h40, 0, 0, 32'h0, 0, 0));                                   // reset state
    tbl.push_back(mk(0, 32'h40, 1, 32'h40, 32'h1000, 1, 0,   0, 0, 32'h0,    0, 0, 1, 1, 0));
    tbl.push_back(lk(32'h40, 1, 1, 32'h1000, 1, 0));
    tbl.push_back(mk(0, 32'h80, 1, 32'h80, 32'h2000, 1, 0,   0, 0, 32'h0,    0, 0, 1, 0, 1));
    tbl.push_back(lk(32'h80, 1, 1, 32'h2000, 0, 1));
    tbl.push_back(mk(0, 32'h40, 1, 32'hC0, 32'h3000, 1, 0,   1, 1, 32'h1000, 1, 0, 1, 0, 1)); // LRU victim way2
    tbl.push_back(lk(32'h80, 0, 0, 32'h0, 0, 0));
    tbl.push_back(lk(32'h40, 1, 1, 32'h1000, 1, 0));
    tbl.push_back(lk(32'hC0, 1, 1, 32'h3000, 0, 1));
    tbl.push_back(mk(0, 32'h40, 1, 32'h40, 32'h2000, 1, 0,   1, 1, 32'h1000, 1, 0, 0, 0, 0)); // no bypass
    tbl.push_back(lk(32'h40, 1, 1, 32'h2000, 1, 0));
    tbl.push_back(mk(0, 32'h80, 1, 32'h80, 32'h4000, 1, 1,   0, 0, 32'h0,    0, 0, 1, 1, 0)); // LRU victim way1
    tbl.push_back(lk(32'h40, 0, 0, 32'h0, 0, 0));
    tbl.push_back(lk(32'h80, 1, 1, 32'h4000, 1, 0));
    tbl.push_back(mk(0, 32'hC0, 1, 32'h100, 32'h5555, 0, 0,  1, 1, 32'h3000, 0, 1, 0, 0, 0)); // not-taken miss
    tbl.push_back(lk(32'h100, 0, 0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 32'h44, 0, 32'h44, 32'h7777, 1, 0,   0, 0, 32'h0,    0, 0, 0, 0, 0)); // ex_valid=0
    tbl.push_back(lk(32'h44, 0, 0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 32'h84, 1, 32'h4C, 32'h5000, 1, 0,   0, 0, 32'h0,    0, 0, 1, 1, 0));
    tbl.push_back(lk(32'h4C, 1, 1, 32'h5000, 1, 0));
`ifdef BTB_PREDICTOR_EN
    tbl.push_back(mk(0, 32'hC0, 1, 32'hC0, 32'h9999, 0, 0,   1, 1, 32'h3000, 0, 1, 0, 0, 0)); // 10->01
    tbl.push_back(lk(32'hC0, 1, 0, 32'h3000, 0, 1));
    tbl.push_back(mk(0, 32'hC0, 1, 32'hC0, 32'h9999, 0, 0,   1, 0, 32'h3000, 0, 1, 0, 0, 0)); // 01->00
    tbl.push_back(mk(0, 32'hC0, 1, 32'hC0, 32'h6000, 1, 0,   1, 0, 32'h3000, 0, 1, 0, 0, 0)); // 00->01
    tbl.push_back(lk(32'hC0, 1, 0, 32'h6000, 0, 1));
`else
    tbl.push_back(mk(0, 32'hC0, 1, 32'hC0, 32'h9999, 0, 0,   1, 1, 32'h3000, 0, 1, 0, 0, 0)); // invalidate
    tbl.push_back(lk(32'hC0, 0, 0, 32'h0, 0, 0));
    tbl.push_back(mk(0, 32'hC0, 1, 32'hC0, 32'h9999, 0, 0,   0, 0, 32'h0,    0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 32'hC0, 1, 32'hC0, 32'h6000, 1, 0,   0, 0, 32'h0,    0, 0, 1, 0, 1)); // invalid way2
    tbl.push_back(lk(32'hC0, 1, 1, 32'h6000, 0, 1));
`endif

    #1;
    foreach (tbl[i]) apply(tbl[i], i);

    // Reset concurrent with an allocating EX update: allocation is dropped
    // and every previously valid entry is gone.
    apply(mk(1, 32'h80, 1, 32'h200, 32'h7000, 1, 0, 0, 0, 32'h0, 0, 0, 0, 0, 0), 100);
    apply(lk(32'h200, 0, 0, 32'h0, 0, 0), 101);
    apply(lk(32'h80,  0, 0, 32'h0, 0, 0), 102);
    apply(lk(32'h4C,  0, 0, 32'h0, 0, 0), 103);
    // Allocation after reset goes to way1 again.
    apply(mk(0, 32'h200, 1, 32'h200, 32'h7000, 1, 1, 0, 0, 32'h0, 0, 0, 1, 1, 0), 104);
    apply(lk(32'h200, 1, 1, 32'h7000, 1, 0), 105);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
